baud_rate_gen: RTL and testbench
================================

Name: baud_rate_gen

Overview:
- Programmable baud-tick generator directly upstream of the UART receive buffer and the transmit side.
- Holds a 16-bit divisor written over the 8-bit I/O bus at ioaddr 2'b10 (low byte) and 2'b11 (high byte).
- Produces a free-running one-cycle tx_enable tick per bit time.
- Produces an rx_enable tick that is re-phased to mid-bit on each start-bit falling edge of RxD. The receive buffer's enable input is driven from rx_enable.

Parameters:
DEFAULT_DIVISOR, 16'd325, divisor loaded at reset; tick period is divisor+1 clk cycles.
FRAME_BITS, 12, rx_enable ticks during which realignment is locked out after a start edge; matches the receiver's 12-tick frame count.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
iocs  input  1  I/O chip select
iorw  input  1  1 = read, 0 = write
ioaddr  input  2  register select; 2'b10 = DB_LOW, 2'b11 = DB_HIGH
databus  inout  8  shared I/O data bus
RxD  input  1  serial receive line, asynchronous to clk
tx_enable  output  1  one-cycle transmit bit tick
rx_enable  output  1  one-cycle receive bit tick, start-bit aligned
divisor_valid  output  1  active divisor is nonzero; ticks running

Behaviour:
- Reset values:
  - db_low = 8'h00; active divisor = DEFAULT_DIVISOR.
  - tx_cnt = rx_cnt = DEFAULT_DIVISOR.
  - tx_enable = rx_enable = 0; divisor_valid = (DEFAULT_DIVISOR != 0).
  - RxD synchroniser flops = 1; rx state RX_FREE; guard = 0.
- Reset mid-operation aborts everything and returns to these values immediately.
- Writes require iocs & ~iorw:
  - ioaddr 10: db_low <= databus.
  - ioaddr 11 (commit): divisor <= {databus, db_low}; tx_cnt and rx_cnt reload with the new divisor; rx state -> RX_FREE; guard <= 0; divisor_valid <= new divisor != 0.
  - A low-byte write alone never changes tick timing.
  - ioaddr 00/01 and any access with iocs = 0 are ignored.
- tx path, when divisor_valid = 1:
  - tx_cnt == 0: tx_enable <= 1 for exactly one cycle; tx_cnt <= divisor.
  - Otherwise tx_cnt decrements and tx_enable <= 0.
  - Period is divisor+1 cycles. The first tick is visible divisor+1 cycles after reset release or commit.
- rx path:
  - RxD passes through a 2-flop synchroniser, then a previous-value flop. Falling edge = prev 1 and current 0.
  - The rx counter runs exactly like the tx path, ticking rx_enable.
  - RX_FREE: on a falling edge, rx_cnt <= divisor >> 1, guard <= FRAME_BITS, state -> RX_GUARD. The next rx_enable lands (divisor>>1)+1 cycles later.
  - RX_GUARD: each rx_enable decrements guard. Further falling edges are ignored. When guard reaches 0, state -> RX_FREE.
- divisor == 0:
  - Both enables held 0; counters hold.
  - rx state forced RX_FREE; edges ignored; divisor_valid = 0.
- Simultaneous events:
  - Commit in the same cycle as a falling edge: commit wins; no realignment; state RX_FREE.
  - Commit in the same cycle as a counter expiry: the tick is suppressed; the counter takes the new divisor.
- databus is high-Z at all times unless the optional feature is enabled.
- Registers are write-only to software. The receive buffer owns read address 00; this block never drives 00/01.

Optional Feature:
- Macro: BAUD_DIVISOR_READBACK_EN.
- Defined: iocs & iorw with ioaddr 10 drives divisor[7:0] on databus; ioaddr 11 drives divisor[15:8]. Reads return the active divisor, not db_low. Bus is high-Z otherwise.
- Undefined: databus is never driven; reads at 10/11 see high-Z.

Test Plan:
1. DEFAULT_DIVISOR = 4, release rst -> tx_enable and rx_enable pulse one cycle at cycles 5, 10, 15, …; divisor_valid = 1.
2. Write 8'h09 to 10, then 8'h00 to 11 -> tx_enable period becomes 10 cycles, first pulse 10 cycles after the commit. Write only 10 = 8'h03 -> period stays 10.
3. Commit divisor 16'h0000 -> no tx_enable or rx_enable pulses for 100 cycles; divisor_valid = 0. Commit 16'h0002 -> pulses resume every 3 cycles.
4. Divisor 9, drop RxD 1->0 -> first rx_enable 5 cycles after the edge is detected (after synchroniser), then every 10. A second falling edge 30 cycles later causes no re-phase. After 12 rx ticks, a new falling edge re-phases again.
5. Commit high byte in the same cycle the synchronised falling edge is detected -> no re-phase; rx state RX_FREE; next rx_enable 10 cycles after the commit.
6. With BAUD_DIVISOR_READBACK_EN, divisor 16'h0145 -> read 10 returns 8'h45, read 11 returns 8'h01, read 00 leaves databus undriven by this block. Without the macro, databus stays Z on all reads.

Source files
------------

// File: rtl/baud_rate_gen.sv
// Programmable baud-tick generator: free-running tx tick plus an rx tick re-phased to mid-bit on start edges.
// Optional BAUD_DIVISOR_READBACK_EN lets software read the active divisor back at ioaddr 10/11.
module baud_rate_gen #(
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd325,
    parameter int unsigned FRAME_BITS      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       RxD,
    output logic       tx_enable,
    output logic       rx_enable,
    output logic       divisor_valid
);

    localparam int unsigned DIV_W   = 16;
    localparam int unsigned GUARD_W = $clog2(FRAME_BITS + 1);

    typedef enum logic {
        RX_FREE,
        RX_GUARD
    } rx_state_e;

    logic [7:0]       db_low_q, db_low_d;
    logic [DIV_W-1:0] divisor_q, divisor_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
    logic             tx_en_q, tx_en_d;
    logic             rx_en_q, rx_en_d;
    logic             valid_q, valid_d;
    logic             sync1_q, sync2_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [GUARD_W-1:0] guard_q, guard_d;

    logic             wr_lo_c, wr_hi_c, fall_c;
    logic [DIV_W-1:0] new_div_c;

    assign wr_lo_c   = iocs & ~iorw & (ioaddr == 2'b10);
    assign wr_hi_c   = iocs & ~iorw & (ioaddr == 2'b11);
    assign fall_c    = prev_q & ~sync2_q;
    assign new_div_c = {databus, db_low_q};

    // Register file, counters, rx synchroniser and rx alignment state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_low_q  <= 8'h00;
            divisor_q <= DEFAULT_DIVISOR;
            tx_cnt_q  <= DEFAULT_DIVISOR;
            rx_cnt_q  <= DEFAULT_DIVISOR;
            tx_en_q   <= 1'b0;
            rx_en_q   <= 1'b0;
            valid_q   <= (DEFAULT_DIVISOR != 16'd0);
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= RX_FREE;
            guard_q   <= '0;
        end else begin
            db_low_q  <= db_low_d;
            divisor_q <= divisor_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_en_q   <= tx_en_d;
            rx_en_q   <= rx_en_d;
            valid_q   <= valid_d;
            sync1_q   <= RxD;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            guard_q   <= guard_d;
        end
    end

    // Next-state: a commit overrides any tick or realignment in the same cycle
    always_comb begin
        db_low_d  = db_low_q;
        divisor_d = divisor_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        tx_en_d   = 1'b0;
        rx_en_d   = 1'b0;
        valid_d   = valid_q;
        state_d   = state_q;
        guard_d   = guard_q;

        if (wr_lo_c) begin
            db_low_d = databus;
        end

        if (wr_hi_c) begin
            divisor_d = new_div_c;
            tx_cnt_d  = new_div_c;
            rx_cnt_d  = new_div_c;
            valid_d   = (new_div_c != 16'd0);
            state_d   = RX_FREE;
            guard_d   = '0;
        end else if (!valid_q) begin
            state_d = RX_FREE;
            guard_d = '0;
        end else begin
            if (tx_cnt_q == 16'd0) begin
                tx_en_d  = 1'b1;
                tx_cnt_d = divisor_q;
            end else begin
                tx_cnt_d = tx_cnt_q - 16'd1;
            end

            if ((state_q == RX_FREE) && fall_c) begin
                rx_cnt_d = divisor_q >> 1;
                guard_d  = GUARD_W'(FRAME_BITS);
                state_d  = RX_GUARD;
            end else if (rx_cnt_q == 16'd0) begin
                rx_en_d  = 1'b1;
                rx_cnt_d = divisor_q;
                if (state_q == RX_GUARD) begin
                    guard_d = guard_q - GUARD_W'(1);
                    if (guard_q <= GUARD_W'(1)) begin
                        state_d = RX_FREE;
                    end
                end
            end else begin
                rx_cnt_d = rx_cnt_q - 16'd1;
            end
        end
    end

    assign tx_enable     = tx_en_q;
    assign rx_enable     = rx_en_q;
    assign divisor_valid = valid_q;

`ifdef BAUD_DIVISOR_READBACK_EN
    logic rd_hit_c;
    assign rd_hit_c = iocs & iorw & ioaddr[1];
    assign databus  = rd_hit_c ? (ioaddr[0] ? divisor_q[15:8] : divisor_q[7:0]) : 8'hzz;
`else
    assign databus = 8'hzz;
`endif

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen: tick periods, divisor commits, zero divisor, rx re-phasing and bus behaviour.
module tb_baud_rate_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       RxD;
    logic       tx_enable;
    logic       rx_enable;
    logic       divisor_valid;
    wire  [7:0] databus;
    logic [7:0] drv;
    logic       drv_en;

    int checks = 0;
    int errors = 0;
    int n;
    int pulses;

    assign databus = drv_en ? drv : 8'hzz;

    always #5 clk = ~clk;

    baud_rate_gen #(
        .DEFAULT_DIVISOR(16'd4),
        .FRAME_BITS     (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .iocs         (iocs),
        .iorw         (iorw),
        .ioaddr       (ioaddr),
        .databus      (databus),
        .RxD          (RxD),
        .tx_enable    (tx_enable),
        .rx_enable    (rx_enable),
        .divisor_valid(divisor_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycles until the selected tick is seen; -1 if the bound expires
    task automatic wait_tick(input bit use_rx, input int limit, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!(use_rx ? rx_enable : tx_enable) && cnt < limit);
        if (!(use_rx ? rx_enable : tx_enable)) cnt = -1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = a;
        drv    = d;
        drv_en = 1'b1;
        step();
        iocs   = 1'b0;
        drv_en = 1'b0;
    endtask

    function automatic int bus_idle();
        return ((databus === 8'hzz) || (databus === 8'h00)) ? 1 : 0;
    endfunction

    initial begin
        rst    = 1'b1;
        iocs   = 1'b0;
        iorw   = 1'b0;
        ioaddr = 2'b00;
        RxD    = 1'b1;
        drv    = 8'h00;
        drv_en = 1'b0;

        // Reset state with DEFAULT_DIVISOR = 4
        step(); step(); step();
        chk("rst_tx", int'(tx_enable), 0);
        chk("rst_rx", int'(rx_enable), 0);
        chk("rst_valid", int'(divisor_valid), 1);
        rst = 1'b0;

        // Test 1: period 5 after reset release
        wait_tick(1'b0, 50, n);
        chk("t1_first_tx", n, 5);
        chk("t1_first_rx", int'(rx_enable), 1);
        step();
        chk("t1_tx_width", int'(tx_enable), 0);
        wait_tick(1'b0, 50, n);
        chk("t1_tx_period", n, 4);
        wait_tick(1'b0, 50, n);
        chk("t1_tx_period2", n, 5);

        // Test 2: divisor 9, low-byte-only write keeps the period
        wr(2'b10, 8'h09);
        wr(2'b11, 8'h00);
        wait_tick(1'b0, 50, n);
        chk("t2_first_tx", n, 10);
        chk("t2_first_rx", int'(rx_enable), 1);
        wr(2'b10, 8'h03);
        wait_tick(1'b0, 50, n);
        chk("t2_tx_after_lo", n, 9);
        wait_tick(1'b0, 50, n);
        chk("t2_tx_period", n, 10);

        // Test 3: zero divisor stops ticks, divisor 2 restarts them
        wr(2'b10, 8'h00);
        wr(2'b11, 8'h00);
        chk("t3_valid0", int'(divisor_valid), 0);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx_enable || rx_enable) pulses++;
        end
        chk("t3_no_pulses", pulses, 0);
        wr(2'b10, 8'h02);
        wr(2'b11, 8'h00);
        chk("t3_valid1", int'(divisor_valid), 1);
        wait_tick(1'b0, 50, n);
        chk("t3_first_tx", n, 3);
        wait_tick(1'b0, 50, n);
        chk("t3_tx_period", n, 3);
        chk("t3_rx_with_tx", int'(rx_enable), 1);

        // Test 4: start-edge re-phase, guard lockout, re-phase after 12 ticks
        wr(2'b10, 8'h09);
        wr(2'b11, 8'h00);
        RxD = 1'b0;
        wait_tick(1'b1, 50, n);
        chk("t4_rephase", n, 8);
        RxD = 1'b1;
        wait_tick(1'b1, 50, n);
        chk("t4_rx_period", n, 10);
        RxD = 1'b0;
        wait_tick(1'b1, 50, n);
        chk("t4_guard_ignores_edge", n, 10);
        RxD = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wait_tick(1'b1, 50, n);
            chk("t4_guard_period", n, 10);
        end
        RxD = 1'b0;
        wait_tick(1'b1, 50, n);
        chk("t4_rephase_after_guard", n, 8);

        // Test 5: commit coinciding with the detected edge wins
        RxD = 1'b1;
        wr(2'b10, 8'h09);
        wr(2'b11, 8'h00);
        step(); step(); step();
        RxD = 1'b0;
        step(); step();
        wr(2'b11, 8'h00);
        wait_tick(1'b1, 50, n);
        chk("t5_commit_beats_edge", n, 10);
        RxD = 1'b1;

        // Test 6: divisor 0x0145, bus reads and full 16-bit period
        wr(2'b10, 8'h45);
        wr(2'b11, 8'h01);
        chk("t6_valid", int'(divisor_valid), 1);
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = 2'b10;
        #1;
`ifdef BAUD_DIVISOR_READBACK_EN
        chk("t6_read_lo", int'(databus), 32'h45);
`else
        chk("t6_read_lo_z", bus_idle(), 1);
`endif
        ioaddr = 2'b11;
        #1;
`ifdef BAUD_DIVISOR_READBACK_EN
        chk("t6_read_hi", int'(databus), 32'h01);
`else
        chk("t6_read_hi_z", bus_idle(), 1);
`endif
        ioaddr = 2'b00;
        #1;
        chk("t6_read_00_z", bus_idle(), 1);
        iocs = 1'b0;
        iorw = 1'b0;
        wait_tick(1'b0, 400, n);
        chk("t6_first_tx", n, 326);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
